// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset and lock supervisor for the iCE40 PLL wrapper.
// Holds the PLL in reset, waits for lock, qualifies it for a stable window,
// then releases the system reset. Any loss of lock restarts the sequence.
// Ports:
//   clk          12 MHz reference clock (also the PLL reference)
//   rst_n        asynchronous active-low reset
//   pll_lock     raw PLL LOCK, asynchronous to clk
//   pll_resetb   PLL RESETB, low holds the PLL in reset
//   sys_rst_n    active-low system reset, high only in RUN
//   ready        high while in RUN
//   timeout      one-cycle pulse when a lock wait expires
//   relock_count lock losses from RUN, saturating at 255
module pll_reset_seq #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       timeout,
  output logic [7:0] relock_count
);

  localparam int unsigned MAX_RS  = (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_RS > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_RS : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   timeout_c;
  logic                   relock_inc_c;
  logic                   pll_resetb_c;
  logic                   sys_rst_n_c;
  logic                   ready_c;
  logic [7:0]             relock_count_c;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock synchronizer, state register and shared cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != ST_RUN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic; a drop beats the stable terminal count and lock
  // beats the timeout terminal count
  always_comb begin
    state_d      = state_q;
    timeout_c    = 1'b0;
    relock_inc_c = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_HOLD;
          timeout_c = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d      = ST_HOLD;
          relock_inc_c = 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Output decode from next state so registered outputs track the transition edge
  always_comb begin
    pll_resetb_c   = (state_d != ST_HOLD);
    sys_rst_n_c    = (state_d == ST_RUN);
    ready_c        = (state_d == ST_RUN);
    relock_count_c = relock_count;
    if (relock_inc_c && (relock_count != 8'hFF)) begin
      relock_count_c = relock_count + 8'd1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_resetb   <= 1'b0;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      timeout      <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      pll_resetb   <= pll_resetb_c;
      sys_rst_n    <= sys_rst_n_c;
      ready        <= ready_c;
      timeout      <= timeout_c;
      relock_count <= relock_count_c;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: expected output values are queued with the
// clk edge after which they must hold, and compared on the falling edge.
module tb_pll_reset_seq;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int SS = 2;

  localparam int S_PRB = 0;
  localparam int S_SRN = 1;
  localparam int S_RDY = 2;
  localparam int S_TMO = 3;
  localparam int S_RLC = 4;

  typedef struct {
    int at;
    int sel;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       ready;
  logic       timeout;
  logic [7:0] relock_count;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  pll_reset_seq #(
    .RESET_CYCLES        (RC),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (TO),
    .SYNC_STAGES         (SS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .pll_resetb   (pll_resetb),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .timeout      (timeout),
    .relock_count (relock_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  function automatic string sname(input int sel);
    case (sel)
      S_PRB:   return "pll_resetb";
      S_SRN:   return "sys_rst_n";
      S_RDY:   return "ready";
      S_TMO:   return "timeout";
      default: return "relock_count";
    endcase
  endfunction

  function automatic int sval(input int sel);
    case (sel)
      S_PRB:   return int'(pll_resetb);
      S_SRN:   return int'(sys_rst_n);
      S_RDY:   return int'(ready);
      S_TMO:   return int'(timeout);
      default: return int'(relock_count);
    endcase
  endfunction

  task automatic exp_at(input int sel, input int at, input int val);
    exp_t e;
    e.at  = at;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_span(input int sel, input int lo, input int hi, input int val);
    for (int a = lo; a <= hi; a++) exp_at(sel, a, val);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare every entry due after the most recent edge
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sname(sb[i].sel), sval(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        check("sb_stale", cyc, sb[i].at);
        sb.delete(i);
      end
    end
  end

  // Drop lock in RUN, restore it one cycle into HOLD, run until RUN again
  task automatic loss_event(input int n, input bit full);
    int d;
    int rl;
    d  = cyc;
    rl = (n > 255) ? 255 : n;
    if (full) begin
      exp_at(S_SRN, d + 2, 1);
      exp_at(S_SRN, d + 3, 0);
      exp_at(S_PRB, d + 2, 1);
      exp_at(S_PRB, d + 3, 0);
      exp_at(S_RDY, d + 3, 0);
      exp_at(S_RLC, d + 2, n - 1);
      exp_at(S_RDY, d + 15, 0);
    end
    exp_at(S_RLC, d + 3, rl);
    exp_at(S_RDY, d + 16, 1);
    pll_lock = 1'b0;
    tick(4);
    pll_lock = 1'b1;
    tick(16);
  endtask

  task automatic restart(output int c0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    int c0;
    int base;
    int w;

    // Reset state
    tick(3);
    check("rst_pll_resetb", int'(pll_resetb), 0);
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_relock", int'(relock_count), 0);

    // Power-up: lock raised 10 cycles after release; first lock sample at c0+11
    rst_n = 1'b1;
    c0 = cyc;
    exp_span(S_PRB, c0 + 1, c0 + RC - 1, 0);
    exp_span(S_PRB, c0 + RC, c0 + 21, 1);
    exp_span(S_SRN, c0 + 1, c0 + 11 + SS + LS - 1, 0);
    exp_at(S_SRN, c0 + 11 + SS + LS, 1);
    exp_span(S_RDY, c0 + 1, c0 + 20, 0);
    exp_at(S_RDY, c0 + 21, 1);
    exp_span(S_TMO, c0 + 1, c0 + 21, 0);
    exp_at(S_RLC, c0 + 21, 0);
    tick(10);
    pll_lock = 1'b1;
    tick(12);

    // Lock glitch in STABLE, dropping exactly at the terminal count
    pll_lock = 1'b0;
    restart(c0);
    exp_span(S_SRN, c0 + 1, c0 + 24, 0);
    exp_at(S_SRN, c0 + 25, 1);
    exp_at(S_RDY, c0 + 24, 0);
    exp_at(S_RDY, c0 + 25, 1);
    exp_span(S_PRB, c0 + RC, c0 + 25, 1);
    exp_span(S_TMO, c0 + 1, c0 + 25, 0);
    exp_at(S_RLC, c0 + 25, 0);
    tick(4);
    pll_lock = 1'b1;
    tick(8);
    pll_lock = 1'b0;
    tick(2);
    pll_lock = 1'b1;
    tick(12);

    // No lock: 32 high / 4 low with a one-cycle timeout pulse per period
    pll_lock = 1'b0;
    restart(c0);
    exp_span(S_PRB, c0 + 1, c0 + RC - 1, 0);
    for (int k = 0; k < 2; k++) begin
      base = c0 + RC + k * (TO + RC);
      exp_span(S_PRB, base, base + TO - 1, 1);
      exp_span(S_PRB, base + TO, base + TO + RC - 1, 0);
      exp_span(S_TMO, base, base + TO - 1, 0);
      exp_at(S_TMO, base + TO, 1);
      exp_span(S_TMO, base + TO + 1, base + TO + RC - 1, 0);
    end
    w = c0 + RC + 2 * (TO + RC);
    exp_at(S_PRB, w, 1);
    tick(w + 29 - cyc);

    // Lock reaches the FSM on the timeout edge: STABLE, no pulse
    pll_lock = 1'b1;
    exp_span(S_TMO, w + 30, w + 40, 0);
    exp_span(S_PRB, w + 30, w + 40, 1);
    exp_at(S_RDY, w + 39, 0);
    exp_at(S_RDY, w + 40, 1);
    exp_at(S_SRN, w + 40, 1);
    exp_at(S_RLC, w + 40, 0);
    tick(12);

    // Repeated lock loss in RUN, then saturation
    for (int n = 1; n <= 3; n++) loss_event(n, 1'b1);
    for (int n = 4; n <= 303; n++) loss_event(n, 1'b0);
    check("relock_sat", int'(relock_count), 255);

    // Async reset between edges while in RUN
    #2;
    check("pre_rst_ready", int'(ready), 1);
    rst_n = 1'b0;
    #1;
    check("async_pll_resetb", int'(pll_resetb), 0);
    check("async_sys_rst_n", int'(sys_rst_n), 0);
    check("async_ready", int'(ready), 0);
    check("async_timeout", int'(timeout), 0);
    check("async_relock", int'(relock_count), 0);
    tick(2);

    check("sb_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
